// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: access-size encoding, address-error exception codes
// and the data-request tag carried from issue to response.
package cpu_defs;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef struct packed {
    logic       load;
    logic [1:0] off;
    logic [1:0] size;
  } dreq_tag_t;

  localparam int unsigned TAG_W = $bits(dreq_tag_t);

  // Encoding 3 is an alias for a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'd3) ? SZ_WORD : s;
  endfunction

endpackage

// File: rtl/dreq_tag_fifo.sv
// In-order tag FIFO for outstanding data requests; the head is visible
// combinationally so the response path can align returned data.
module dreq_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [TAG_W-1:0]         tag_i,
  input  logic                     pop_i,
  output logic [TAG_W-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_ok;

  // A pop against an empty FIFO is a stray response and is dropped.
  always_comb begin
    pop_ok   = pop_i & (cnt_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_i & ~pop_ok)      cnt_d = cnt_q + CNT_W'(1);
    else if (~push_i & pop_ok) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i & ~reset) mem_q[wr_ptr_q] <= tag_i;
  end

  assign head_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/dreq_issue_stage.sv
// Data-request issue stage: holds one instruction, checks alignment, issues
// memory requests and tracks outstanding requests in an in-order tag FIFO.
module dreq_issue_stage
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_load,
  input  logic                    in_store,
  input  logic [1:0]              in_size,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [31:0]             in_wdata,
  input  logic                    in_ex,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_ex,
  output logic [4:0]              out_exccode,
  output logic [ADDR_W-1:0]       out_badvaddr,
  output logic                    out_issued,
  output logic                    req,
  output logic                    req_wr,
  output logic [1:0]              req_size,
  output logic [3:0]              req_wstrb,
  output logic [ADDR_W-1:0]       req_addr,
  output logic [31:0]             req_wdata,
  input  logic                    req_addr_ok,
  input  logic                    resp_ok,
  output logic                    resp_load,
  output logic [1:0]              resp_off,
  output logic [1:0]              resp_size,
  output logic [$clog2(DEPTH):0]  busy_cnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              valid_q, valid_d;
  logic              load_q, load_d;
  logic              store_q, store_d;
  logic              ex_q, ex_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic       vld, mem_op, misalign, addr_err, go;
  logic [1:0] sz;
  dreq_tag_t  push_tag, head_tag;

  // Handshake, exception and request qualification; reset masks the held entry.
  always_comb begin
    vld          = valid_q & ~reset;
    mem_op       = load_q | store_q;
    sz           = norm_size(size_q);
    misalign     = ((sz == SZ_HALF) & addr_q[0]) | ((sz == SZ_WORD) & (|addr_q[1:0]));
    addr_err     = vld & ~ex_q & mem_op & misalign;
    out_ex       = vld & (ex_q | (mem_op & misalign));
    out_exccode  = '0;
    if (addr_err) out_exccode = load_q ? EXC_ADEL : EXC_ADES;
    out_badvaddr = addr_q;
    req          = vld & mem_op & ~out_ex & ~flush & out_ready & (busy_cnt < CNT_W'(DEPTH));
    out_issued   = req & req_addr_ok;
    go           = out_issued | ~mem_op | out_ex;
    out_valid    = vld & go;
    in_ready     = ~vld | (go & out_ready);
  end

  // Request channel payload: lane strobes and replicated store data.
  always_comb begin
    req_wr    = store_q;
    req_size  = sz;
    req_addr  = addr_q;
    req_wstrb = 4'h0;
    req_wdata = wdata_q;
    case (sz)
      SZ_BYTE: begin
        req_wstrb = 4'b0001 << addr_q[1:0];
        req_wdata = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        req_wstrb = 4'b0011 << {addr_q[1], 1'b0};
        req_wdata = {2{wdata_q[15:0]}};
      end
      default: req_wstrb = 4'hF;
    endcase
    if (!store_q) req_wstrb = 4'h0;
  end

  always_comb begin
    valid_d = valid_q;
    load_d  = load_q;
    store_d = store_q;
    ex_d    = ex_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (in_ready) begin
      valid_d = in_valid;
      load_d  = in_load;
      store_d = in_store;
      ex_d    = in_ex;
      size_d  = in_size;
      addr_d  = in_addr;
      wdata_d = in_wdata;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    load_q  <= load_d;
    store_q <= store_d;
    ex_q    <= ex_d;
    size_q  <= size_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    push_tag      = '0;
    push_tag.load = load_q;
    push_tag.off  = addr_q[1:0];
    push_tag.size = sz;
  end

  dreq_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (out_issued),
    .tag_i  (push_tag),
    .pop_i  (resp_ok),
    .head_o (head_tag),
    .cnt_o  (busy_cnt)
  );

  assign resp_load = head_tag.load;
  assign resp_off  = head_tag.off;
  assign resp_size = head_tag.size;

endmodule

// File: tb/tb_dreq_issue_stage.sv
// Bench for dreq_issue_stage: directed scenarios with literal expectations,
// then randomized traffic against a queue-based behavioural model.
module tb_dreq_issue_stage;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, in_valid, in_ready, in_load, in_store, in_ex, flush;
  logic [1:0]        in_size;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_wdata;
  logic              out_valid, out_ready, out_ex, out_issued;
  logic [4:0]        out_exccode;
  logic [ADDR_W-1:0] out_badvaddr;
  logic              req, req_wr, req_addr_ok, resp_ok, resp_load;
  logic [1:0]        req_size, resp_off, resp_size;
  logic [3:0]        req_wstrb;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [$clog2(DEPTH):0] busy_cnt;

  dreq_issue_stage #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_size(in_size), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_ex(in_ex), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ex(out_ex), .out_exccode(out_exccode),
    .out_badvaddr(out_badvaddr), .out_issued(out_issued), .req(req), .req_wr(req_wr),
    .req_size(req_size), .req_wstrb(req_wstrb), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_addr_ok(req_addr_ok), .resp_ok(resp_ok),
    .resp_load(resp_load), .resp_off(resp_off), .resp_size(resp_size),
    .busy_cnt(busy_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: the held instruction and a queue of outstanding tags {load, off, size}.
  bit        m_valid, m_load, m_store, m_ex;
  bit [1:0]  m_size;
  bit [31:0] m_addr, m_wdata;
  bit [4:0]  m_q[$];
  bit        e_ready, e_issued;
  bit [1:0]  e_sz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic settle();
    bit ev, mem, mis, e_ex, e_req, go;
    bit [31:0] w;
    int strb;
    #1;
    e_sz  = (m_size == 2'd3) ? 2'd2 : m_size;
    ev    = m_valid && !reset;
    mem   = m_load || m_store;
    mis   = (e_sz == 2'd1 && m_addr % 2 != 0) || (e_sz == 2'd2 && m_addr % 4 != 0);
    e_ex  = ev && (m_ex || (mem && mis));
    e_req = ev && mem && !e_ex && !flush && out_ready && (m_q.size() < DEPTH);
    e_issued = e_req && req_addr_ok;
    go      = e_issued || !mem || e_ex;
    e_ready = !ev || (go && out_ready);
    chk("in_ready", in_ready, e_ready);
    chk("out_valid", out_valid, ev && go);
    chk("out_ex", out_ex, e_ex);
    chk("req", req, e_req);
    chk("out_issued", out_issued, e_issued);
    chk("busy_cnt", busy_cnt, m_q.size());
    if (e_ex && !m_ex) begin
      chk("out_exccode", out_exccode, m_load ? 4 : 5);
      chk("out_badvaddr", out_badvaddr, m_addr);
    end
    if (e_req) begin
      chk("req_wr", req_wr, m_store);
      chk("req_size", req_size, e_sz);
      chk("req_addr", req_addr, m_addr);
      if (m_store) begin
        if (e_sz == 0)      begin strb = 1 << (m_addr % 4); w = 32'(m_wdata[7:0]) * 32'h0101_0101; end
        else if (e_sz == 1) begin strb = 3 << (m_addr & 2); w = 32'(m_wdata[15:0]) * 32'h0001_0001; end
        else                begin strb = 15;                w = m_wdata; end
        chk("req_wstrb", req_wstrb, strb);
        chk("req_wdata", req_wdata, w);
      end else begin
        chk("req_wstrb_load", req_wstrb, 0);
      end
    end
    if (m_q.size() > 0) begin
      chk("resp_load", resp_load, m_q[0][4]);
      chk("resp_off", resp_off, m_q[0][3:2]);
      chk("resp_size", resp_size, m_q[0][1:0]);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0;
      m_q.delete();
    end else begin
      if (resp_ok && m_q.size() > 0) void'(m_q.pop_front());
      if (e_issued) m_q.push_back({m_load, m_addr[1:0], e_sz});
      if (flush) m_valid = 1'b0;
      else if (e_ready) begin
        m_valid = in_valid; m_load = in_load; m_store = in_store; m_ex = in_ex;
        m_size = in_size; m_addr = in_addr; m_wdata = in_wdata;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    edge_step();
  endtask

  task automatic drive(input bit v, input bit ld, input bit st, input bit [1:0] sz,
                       input bit [31:0] a, input bit [31:0] wd);
    in_valid = v; in_load = ld; in_store = st; in_size = sz; in_addr = a; in_wdata = wd;
  endtask

  bit [31:0] la[5];

  initial begin
    reset = 1'b1; flush = 1'b0; in_ex = 1'b0; out_ready = 1'b1; req_addr_ok = 1'b1;
    resp_ok = 1'b0;
    drive(1, 1, 0, 2, 32'h40, 0);
    @(negedge clk); @(negedge clk);
    settle();
    chk("rst_req", req, 0); chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1); chk("rst_out_ex", out_ex, 0);
    edge_step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    settle();
    chk("post_rst_in_ready", in_ready, 1); chk("post_rst_req", req, 0);
    chk("post_rst_busy", busy_cnt, 0);
    edge_step();

    // Word store, byte store, misaligned half load.
    drive(1, 0, 1, 2, 32'h1004, 32'hDEAD_BEEF); cyc();
    drive(0, 0, 0, 0, 0, 0); settle();
    chk("ws_wstrb", req_wstrb, 4'hF); chk("ws_wdata", req_wdata, 32'hDEAD_BEEF);
    chk("ws_issued", out_issued, 1);
    edge_step();
    drive(1, 0, 1, 0, 32'h1003, 32'h5A); settle();
    chk("ws_busy", busy_cnt, 1);
    edge_step();
    drive(0, 0, 0, 0, 0, 0); settle();
    chk("bs_wstrb", req_wstrb, 4'b1000); chk("bs_wdata", req_wdata, 32'h5A5A_5A5A);
    edge_step();
    drive(1, 1, 0, 1, 32'h2001, 0); cyc();
    drive(0, 0, 0, 0, 0, 0); settle();
    chk("hl_req", req, 0); chk("hl_ex", out_ex, 1); chk("hl_code", out_exccode, 4);
    chk("hl_bad", out_badvaddr, 32'h2001); chk("hl_busy", busy_cnt, 2);
    edge_step();
    resp_ok = 1'b1; settle();
    chk("drain0_off", resp_off, 0); chk("drain0_size", resp_size, 2);
    edge_step();
    settle();
    chk("drain1_off", resp_off, 3); chk("drain1_size", resp_size, 0);
    edge_step();
    resp_ok = 1'b0;

    // Five byte loads fill the FIFO; the fifth waits for a response.
    la[0] = 32'h101; la[1] = 32'h102; la[2] = 32'h103; la[3] = 32'h100; la[4] = 32'h101;
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 0, 0, la[k], 0); cyc();
    end
    drive(0, 0, 0, 0, 0, 0); settle();
    chk("full_busy", busy_cnt, 4); chk("full_req", req, 0); chk("full_in_ready", in_ready, 0);
    edge_step();
    resp_ok = 1'b1; settle();
    chk("full_pop_req", req, 0); chk("full_pop_off", resp_off, 1); chk("full_pop_load", resp_load, 1);
    edge_step();
    resp_ok = 1'b0; settle();
    chk("unblk_req", req, 1); chk("unblk_issued", out_issued, 1); chk("unblk_busy", busy_cnt, 3);
    edge_step();
    resp_ok = 1'b1; cyc(); cyc();
    resp_ok = 1'b0;

    // Simultaneous push and pop at busy_cnt=2.
    drive(1, 1, 0, 0, 32'h1002, 0); cyc();
    drive(0, 0, 0, 0, 0, 0); resp_ok = 1'b1; settle();
    chk("pp_req", req, 1); chk("pp_busy_before", busy_cnt, 2); chk("pp_head_before", resp_off, 0);
    edge_step();
    resp_ok = 1'b0; settle();
    chk("pp_busy_after", busy_cnt, 2); chk("pp_head_after", resp_off, 1);
    edge_step();

    // Flush with a load held and two requests in flight.
    drive(1, 1, 0, 2, 32'h3000, 0); cyc();
    drive(0, 0, 0, 0, 0, 0); flush = 1'b1; settle();
    chk("fl_req", req, 0); chk("fl_busy", busy_cnt, 2);
    edge_step();
    flush = 1'b0; settle();
    chk("fl_after_valid", out_valid, 0); chk("fl_after_req", req, 0);
    chk("fl_after_ready", in_ready, 1);
    edge_step();
    resp_ok = 1'b1; cyc(); cyc();
    resp_ok = 1'b1; settle();
    chk("fl_drained", busy_cnt, 0);
    edge_step();
    resp_ok = 1'b0;

    // Randomized traffic, including stray responses, flushes and resets.
    for (int n = 0; n < 3000; n++) begin
      bit [31:0] a;
      int op;
      reset    = ($urandom_range(0, 199) == 0);
      op       = $urandom_range(0, 3);
      a        = $urandom();
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      drive($urandom_range(0, 3) != 0, op == 1, op == 2, 2'($urandom_range(0, 3)), a, $urandom());
      in_ex       = ($urandom_range(0, 15) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      req_addr_ok = ($urandom_range(0, 3) != 0);
      resp_ok     = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
